aes32_round_seq: RTL

//  Sequences one full AES round (128-bit state) through a single aes32 byte-wide datapath.

---
 rtl/aes32_round_seq_pkg.sv | 56 +++++
 rtl/aes32_round_seq_aes32.sv | 41 ++++
 rtl/aes32_round_seq.sv | 101 ++++++++++
 3 files changed

// File: rtl/aes32_round_seq_pkg.sv
// Shared types and GF(2^8) helpers for the sequenced AES round.
// Pure definitions: no latency, no flow control.
// Word select implements ShiftRows/InvShiftRows as a 2-bit modular column offset.
package aes32_round_seq_pkg;

    localparam int STEP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    // 2-bit arithmetic wraps mod 4, which is exactly the row rotation.
    function automatic logic [1:0] wsel(input logic [1:0] col, input logic [1:0] bs, input logic dec);
        return dec ? (col - bs) : (col + bs);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse (and maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

endpackage

// File: rtl/aes32_round_seq_aes32.sv
// Single-sbox aes32 byte op: rd = rs1 ^ rol(mix?(sbox(rs2.byte[bs])), 8*bs).
// Latency: combinational.
// Backpressure: none; operand byte is forced to zero when valid is low.
module aes32
    import aes32_round_seq_pkg::*;
(
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [1:0]  bs,
    input  logic        dec,
    input  logic        mix,
    output logic [31:0] rd
);

    logic [7:0]  si;
    logic [7:0]  inv;
    logic [7:0]  so;
    logic [31:0] mixed;
    logic [31:0] rot;

    always_comb begin
        si    = valid ? rs2[{bs, 3'b000} +: 8] : 8'h00;
        // One shared GF inverse; the affine step moves before or after it.
        inv   = gf_inv(dec ? aff_inv(si) : si);
        so    = dec ? inv : aff_fwd(inv);
        mixed = {24'h000000, so};
        if (mix && dec)
            mixed = {gf_mul(so, 8'h0b), gf_mul(so, 8'h0d), gf_mul(so, 8'h09), gf_mul(so, 8'h0e)};
        else if (mix)
            mixed = {gf_mul(so, 8'h03), so, so, gf_mul(so, 8'h02)};
        case (bs)
            2'd0:    rot = mixed;
            2'd1:    rot = {mixed[23:0], mixed[31:24]};
            2'd2:    rot = {mixed[15:0], mixed[31:16]};
            default: rot = {mixed[7:0],  mixed[31:8]};
        endcase
        rd = rs1 ^ rot;
    end

endmodule

// File: rtl/aes32_round_seq.sv
// One AES round on a 128-bit state via 16 sequential aes32 byte ops.
// Latency: rsp_valid 16 cycles after accept; one request in flight.
// Backpressure: req_ready only in IDLE; result held in DONE until rsp_ready.
module aes32_round_seq
    import aes32_round_seq_pkg::*;
(
    input  logic         g_clk,
    input  logic         g_reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_dec,
    input  logic         req_mix,
    input  logic [127:0] req_state,
    input  logic [127:0] req_rkey,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_state
);

    fsm_t              st_q;
    fsm_t              st_d;
    logic [STEP_W-1:0] step_q;
    logic              dec_q;
    logic              mix_q;
    logic [3:0][31:0]  state_q;
    logic [3:0][31:0]  rkey_q;
    logic [3:0][31:0]  acc_q;

    logic [1:0]  col;
    logic [1:0]  bs;
    logic        run;
    logic        accept;
    logic [31:0] op_rs1;
    logic [31:0] op_rs2;
    logic [31:0] op_rd;

    assign col    = step_q[3:2];
    assign bs     = step_q[1:0];
    assign run    = (st_q == ST_RUN);
    assign accept = req_valid && req_ready;

    // First byte of a column seeds the accumulator with the round key.
    assign op_rs1 = (bs == 2'd0) ? rkey_q[col] : acc_q[col];
    assign op_rs2 = state_q[wsel(col, bs, dec_q)];

    aes32 u_aes32 (
        .valid (run),
        .rs1   (op_rs1),
        .rs2   (op_rs2),
        .bs    (bs),
        .dec   (dec_q),
        .mix   (mix_q),
        .rd    (op_rd)
    );

    always_comb begin
        st_d      = st_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_state = acc_q;
        case (st_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) st_d = ST_RUN;
            end
            ST_RUN: begin
                if (&step_q) st_d = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            st_q    <= ST_IDLE;
            step_q  <= '0;
            dec_q   <= 1'b0;
            mix_q   <= 1'b0;
            state_q <= '0;
            rkey_q  <= '0;
            acc_q   <= '0;
        end else begin
            st_q <= st_d;
            if (accept) begin
                step_q  <= '0;
                dec_q   <= req_dec;
                mix_q   <= req_mix;
                state_q <= req_state;
                rkey_q  <= req_rkey;
            end else if (run) begin
                acc_q[col] <= op_rd;
                if (!(&step_q)) step_q <= step_q + 1'b1;
            end
        end
    end

endmodule
